// File: rtl/instr_encoder.sv
// instr_encoder
//   Packs RV32 instruction fields (R, I-arith, I-load, S, SB) into 32-bit words.
//   I, S and SB immediates are range-checked. Legal words are queued in a small
//   FIFO, each tagged with a sequential instruction-memory word address.
//   The self-test program loader uses this block ahead of the CPU.
// Ports
//   clk_i, rst_i               clock; synchronous active-high reset
//   req_valid_i / req_ready_o  encode request handshake
//   req_type_i                 0=R 1=I-arith 2=I-load 3=S 4=SB (5..7 illegal)
//   rd_i, rs1_i, rs2_i         register fields
//   funct3_i, funct7_i         function fields
//   imm_i                      signed immediate (SB in halfword units)
//   wr_valid_o / wr_ready_i    instruction-memory write handshake (FIFO head)
//   wr_addr_o, wr_data_o       head word address and encoded instruction
//   err_o                      pulse one cycle after a rejected request
//   err_count_o                saturating rejected-request count
//   level_o                    FIFO occupancy
module instr_encoder #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 4,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [2:0]               req_type_i,
  input  logic [4:0]               rd_i,
  input  logic [4:0]               rs1_i,
  input  logic [4:0]               rs2_i,
  input  logic [2:0]               funct3_i,
  input  logic [6:0]               funct7_i,
  input  logic [31:0]              imm_i,
  output logic                     wr_valid_o,
  input  logic                     wr_ready_i,
  output logic [ADDR_W-1:0]        wr_addr_o,
  output logic [31:0]              wr_data_o,
  output logic                     err_o,
  output logic [7:0]               err_count_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IARI = 7'b0010011;
  localparam logic [6:0] OP_ILD  = 7'b0000011;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_SB   = 7'b1100011;

  logic [31:0]       word;
  logic              legal;
  logic              imm_fits;

  logic [31:0]       mem_data [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [LVL_W-1:0]  level;
  logic [ADDR_W-1:0] addr_cnt;
  logic              err;
  logic [7:0]        err_cnt;

  logic              accept;
  logic              push;
  logic              pop;
  logic              head_valid;

  // A 12-bit signed immediate sign-extends to 32 bits only if bits 31..11 agree.
  assign imm_fits = (&imm_i[31:11]) | ~(|imm_i[31:11]);

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (req_type_i)
      3'd0: begin
        word  = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, OP_R};
        legal = 1'b1;
      end
      3'd1: begin
        word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_IARI};
        legal = imm_fits;
      end
      3'd2: begin
        word  = {imm_i[11:0], rs1_i, funct3_i, rd_i, OP_ILD};
        legal = imm_fits;
      end
      3'd3: begin
        word  = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OP_S};
        legal = imm_fits;
      end
      3'd4: begin
        // imm_i already holds the byte offset shifted right by one.
        word  = {imm_i[11], imm_i[9:4], rs2_i, rs1_i, funct3_i, imm_i[3:0], imm_i[10], OP_SB};
        legal = imm_fits;
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // Readiness depends only on registered occupancy, so a full FIFO refuses
  // even in a cycle where the head is being popped.
  assign req_ready_o = (level != LVL_W'(DEPTH));
  assign accept      = req_valid_i & req_ready_o;
  assign push        = accept & legal;
  assign head_valid  = (level != '0);
  assign pop         = head_valid & wr_ready_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= word;
      mem_addr[wr_ptr] <= addr_cnt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      addr_cnt <= ADDR_W'(BASE_ADDR);
      err      <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + 1'b1;
        addr_cnt <= addr_cnt + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
      err <= accept & ~legal;
      if (accept && !legal && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 1'b1;
      end
    end
  end

  // Storage is not cleared by reset, so the head fields are gated to zero when empty.
  assign wr_valid_o  = head_valid;
  assign wr_data_o   = head_valid ? mem_data[rd_ptr] : '0;
  assign wr_addr_o   = head_valid ? mem_addr[rd_ptr] : '0;
  assign err_o       = err;
  assign err_count_o = err_cnt;
  assign level_o     = level;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder
//   Directed-vector bench for instr_encoder. A second instance with a 2-bit
//   address counter shares the stimulus and is used for the wrap scenario.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [2:0]  req_type = '0;
  logic [4:0]  rd = '0;
  logic [4:0]  rs1 = '0;
  logic [4:0]  rs2 = '0;
  logic [2:0]  funct3 = '0;
  logic [6:0]  funct7 = '0;
  logic [31:0] imm = '0;
  logic        wr_ready = 1'b0;

  logic        req_ready;
  logic        wr_valid;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic        err;
  logic [7:0]  err_count;
  logic [2:0]  level;

  logic        req_ready_w;
  logic        wr_valid_w;
  logic [1:0]  wr_addr_w;
  logic [31:0] wr_data_w;
  logic        err_w;
  logic [7:0]  err_count_w;
  logic [2:0]  level_w;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(10), .DEPTH(4), .BASE_ADDR(0)) dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_type_i(req_type), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
    .wr_valid_o(wr_valid), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr),
    .wr_data_o(wr_data), .err_o(err), .err_count_o(err_count), .level_o(level)
  );

  instr_encoder #(.ADDR_W(2), .DEPTH(4), .BASE_ADDR(0)) dut_w (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready_w),
    .req_type_i(req_type), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .funct3_i(funct3), .funct7_i(funct7), .imm_i(imm),
    .wr_valid_o(wr_valid_w), .wr_ready_i(wr_ready), .wr_addr_o(wr_addr_w),
    .wr_data_o(wr_data_w), .err_o(err_w), .err_count_o(err_count_w), .level_o(level_w)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] t, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] i);
    req_type  = t;
    rd        = d;
    rs1       = s1;
    rs2       = s2;
    funct3    = f3;
    funct7    = f7;
    imm       = i;
    req_valid = 1'b1;
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    wr_ready  = 1'b0;
    rst       = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++; if (wr_valid !== 1'b0) begin $display("FAIL reset_wr_valid: got %0h, expected 0", wr_valid); n_err++; end
    n_vec++; if (level !== 3'd0) begin $display("FAIL reset_level: got %0d, expected 0", level); n_err++; end
    n_vec++; if (wr_data !== 32'h0 || wr_addr !== 10'h0) begin
      $display("FAIL reset_head: got data %h addr %0h, expected 0/0", wr_data, wr_addr); n_err++; end
    n_vec++; if (err !== 1'b0 || err_count !== 8'd0) begin
      $display("FAIL reset_err: got err %0h count %0d, expected 0/0", err, err_count); n_err++; end
    n_vec++; if (req_ready !== 1'b1) begin $display("FAIL reset_req_ready: got %0h, expected 1", req_ready); n_err++; end
  endtask

  task automatic test_addi();
    wr_ready = 1'b0;
    set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    req_valid = 1'b0;
    n_vec++; if (wr_valid !== 1'b1 || wr_data !== 32'h00500093 || wr_addr !== 10'd0) begin
      $display("FAIL addi: got v%0h %h @%0d, expected v1 00500093 @0", wr_valid, wr_data, wr_addr); n_err++; end
    step();
    n_vec++; if (wr_data !== 32'h00500093 || level !== 3'd1) begin
      $display("FAIL addi_hold: got %h level %0d, expected 00500093 level 1", wr_data, level); n_err++; end
    wr_ready = 1'b1;
    step();
    n_vec++; if (wr_valid !== 1'b0 || level !== 3'd0) begin
      $display("FAIL addi_pop: got v%0h level %0d, expected v0 level 0", wr_valid, level); n_err++; end
  endtask

  task automatic test_back_to_back();
    wr_ready = 1'b1;
    set_req(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'hDEADBEEF);
    step();
    n_vec++; if (wr_valid !== 1'b1 || wr_data !== 32'h002081B3 || wr_addr !== 10'd1) begin
      $display("FAIL b2b_add: got v%0h %h @%0d, expected v1 002081B3 @1", wr_valid, wr_data, wr_addr); n_err++; end
    set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd4);
    step();
    n_vec++; if (wr_valid !== 1'b1 || wr_data !== 32'hFE20AE23 || wr_addr !== 10'd2 || level !== 3'd1) begin
      $display("FAIL b2b_sw: got %h @%0d level %0d, expected FE20AE23 @2 level 1", wr_data, wr_addr, level); n_err++; end
    set_req(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, -32'sd2);
    step();
    n_vec++; if (wr_valid !== 1'b1 || wr_data !== 32'hFE208EE3 || wr_addr !== 10'd3) begin
      $display("FAIL b2b_beq: got %h @%0d, expected FE208EE3 @3", wr_data, wr_addr); n_err++; end
    req_valid = 1'b0;
    step();
    n_vec++; if (wr_valid !== 1'b0) begin $display("FAIL b2b_drain: got v%0h, expected 0", wr_valid); n_err++; end
  endtask

  task automatic test_illegal();
    wr_ready = 1'b1;
    set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
    step();
    req_valid = 1'b0;
    n_vec++; if (err !== 1'b1 || err_count !== 8'd1 || wr_valid !== 1'b0) begin
      $display("FAIL range_2048: got err %0h cnt %0d v%0h, expected 1/1/v0", err, err_count, wr_valid); n_err++; end
    step();
    n_vec++; if (err !== 1'b0) begin $display("FAIL err_pulse: got %0h, expected 0", err); n_err++; end
    set_req(3'd6, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0);
    step();
    n_vec++; if (err !== 1'b1 || err_count !== 8'd2 || wr_valid !== 1'b0) begin
      $display("FAIL type6: got err %0h cnt %0d v%0h, expected 1/2/v0", err, err_count, wr_valid); n_err++; end
    set_req(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, -32'sd2049);
    step();
    n_vec++; if (err_count !== 8'd3 || wr_valid !== 1'b0) begin
      $display("FAIL range_m2049: got cnt %0d v%0h, expected 3/v0", err_count, wr_valid); n_err++; end
    set_req(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
    step();
    n_vec++; if (err !== 1'b0 || wr_valid !== 1'b1 || wr_data !== 32'h80000113 || wr_addr !== 10'd4) begin
      $display("FAIL legal_after_err: got err %0h %h @%0d, expected 0 80000113 @4", err, wr_data, wr_addr); n_err++; end
    set_req(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 32'd8);
    step();
    req_valid = 1'b0;
    n_vec++; if (wr_valid !== 1'b1 || wr_data !== 32'h00812283 || wr_addr !== 10'd5) begin
      $display("FAIL lw: got %h @%0d, expected 00812283 @5", wr_data, wr_addr); n_err++; end
    step();
  endtask

  task automatic test_saturate();
    set_req(3'd7, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    repeat (256) step();
    req_valid = 1'b0;
    n_vec++; if (err_count !== 8'd255 || err !== 1'b1) begin
      $display("FAIL saturate: got cnt %0d err %0h, expected 255/1", err_count, err); n_err++; end
    step();
    n_vec++; if (err_count !== 8'd255 || err !== 1'b0) begin
      $display("FAIL saturate_hold: got cnt %0d err %0h, expected 255/0", err_count, err); n_err++; end
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0); step();
    set_req(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); step();
    set_req(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); step();
    set_req(3'd1, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); step();
    set_req(3'd0, 5'd5, 5'd6, 5'd7, 3'd0, 7'h20, 32'h12345678);
    step();
    n_vec++; if (req_ready !== 1'b0 || level !== 3'd4) begin
      $display("FAIL bp_full: got ready %0h level %0d, expected 0/4", req_ready, level); n_err++; end
    wr_ready = 1'b1;
    n_vec++; if (req_ready !== 1'b0 || wr_addr !== 10'd0 || wr_data !== 32'h00000093) begin
      $display("FAIL bp_head0: got ready %0h %h @%0d, expected 0 00000093 @0", req_ready, wr_data, wr_addr); n_err++; end
    step();
    n_vec++; if (level !== 3'd3 || req_ready !== 1'b1 || wr_addr !== 10'd1 || wr_data !== 32'h00100113) begin
      $display("FAIL bp_head1: got level %0d %h @%0d, expected 3 00100113 @1", level, wr_data, wr_addr); n_err++; end
    step();
    req_valid = 1'b0;
    n_vec++; if (level !== 3'd3 || wr_addr !== 10'd2 || wr_data !== 32'h00200193) begin
      $display("FAIL bp_head2: got level %0d %h @%0d, expected 3 00200193 @2", level, wr_data, wr_addr); n_err++; end
    step();
    n_vec++; if (wr_addr !== 10'd3 || wr_data !== 32'h00300213) begin
      $display("FAIL bp_head3: got %h @%0d, expected 00300213 @3", wr_data, wr_addr); n_err++; end
    step();
    n_vec++; if (wr_valid !== 1'b1 || wr_addr !== 10'd4 || wr_data !== 32'h407302B3) begin
      $display("FAIL bp_fifth: got v%0h %h @%0d, expected v1 407302B3 @4", wr_valid, wr_data, wr_addr); n_err++; end
    step();
    n_vec++; if (wr_valid !== 1'b0 || level !== 3'd0) begin
      $display("FAIL bp_drain: got v%0h level %0d, expected 0/0", wr_valid, level); n_err++; end
  endtask

  task automatic test_wrap();
    logic [1:0] exp_addr [6];
    exp_addr = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    wr_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      step();
      n_vec++; if (wr_valid_w !== 1'b1 || wr_addr_w !== exp_addr[k] || wr_data_w !== 32'h00500093) begin
        $display("FAIL wrap_%0d: got v%0h %h @%0d, expected v1 00500093 @%0d",
                 k, wr_valid_w, wr_data_w, wr_addr_w, exp_addr[k]); n_err++; end
    end
    req_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1); step();
    set_req(3'd1, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2); step();
    set_req(3'd1, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3); step();
    req_valid = 1'b0;
    n_vec++; if (level !== 3'd3) begin $display("FAIL mid_fill: got level %0d, expected 3", level); n_err++; end
    rst = 1'b1;
    step();
    n_vec++; if (wr_valid !== 1'b0 || level !== 3'd0 || wr_data !== 32'h0) begin
      $display("FAIL mid_reset: got v%0h level %0d %h, expected 0/0/0", wr_valid, level, wr_data); n_err++; end
    rst = 1'b0;
    set_req(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    step();
    req_valid = 1'b0;
    n_vec++; if (wr_addr !== 10'd0 || wr_data !== 32'h00500093 || level !== 3'd1) begin
      $display("FAIL mid_after: got %h @%0d level %0d, expected 00500093 @0 level 1", wr_data, wr_addr, level); n_err++; end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_illegal();
    test_saturate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
